// File: rtl/updn_cnt_scheduler.sv
// Two-requester round-robin scheduler that owns a shared modulo-2^WIDTH up/down counter.
// Each granted session counts a latched number of steps in a latched direction.
module updn_cnt_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [WIDTH-1:0] steps0,
  input  logic [WIDTH-1:0] steps1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_ptr;
  logic             r_owner;
  logic             r_dir;

  logic             w_any;
  logic             w_win;
  logic             w_dir;
  logic [WIDTH-1:0] w_steps;
  logic [1:0]       w_win_onehot;
  logic             w_owner_req;

  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign w_any        = req0 | req1;
  assign w_win        = (req0 & req1) ? r_ptr : req1;
  assign w_dir        = w_win ? dir1 : dir0;
  assign w_steps      = w_win ? steps1 : steps0;
  assign w_win_onehot = w_win ? 2'b10 : 2'b01;
  assign w_owner_req  = r_owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 2'b00;
          if (clr) begin
            r_cnt <= '0;
          end
          if (w_any) begin
            r_owner <= w_win;
            r_dir   <= w_dir;
            r_rem   <= w_steps;
            r_gnt   <= w_win_onehot;
            r_busy  <= 1'b1;
            if (w_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_onehot;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!w_owner_req) begin
            // Owner walked away: drop the session without touching cnt.
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_rem   <= '0;
            r_ptr   <= ~r_owner;
          end else begin
            r_cnt <= r_dir ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
            r_rem <= r_rem - WIDTH'(1);
            if (r_rem == WIDTH'(1)) begin
              r_state <= S_DONE;
              r_done  <= r_gnt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 2'b00;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_ptr   <= ~r_owner;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 2'b00;
          r_done  <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_updn_cnt_scheduler.sv
// Self-checking bench: per-cycle vectors with hand-derived expectations, checked via a scoreboard queue.
module tb_updn_cnt_scheduler;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             req0;
  logic             req1;
  logic             dir0;
  logic             dir1;
  logic [WIDTH-1:0] steps0;
  logic [WIDTH-1:0] steps1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] cnt;

  updn_cnt_scheduler #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .req0   (req0),
    .req1   (req1),
    .dir0   (dir0),
    .dir1   (dir1),
    .steps0 (steps0),
    .steps1 (steps1),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .cnt    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             clr;
    logic             req0;
    logic             req1;
    logic             dir0;
    logic             dir1;
    logic [WIDTH-1:0] steps0;
    logic [WIDTH-1:0] steps1;
    logic [1:0]       exp_gnt;
    logic [1:0]       exp_done;
    logic             exp_busy;
    logic [WIDTH-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    int               id;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_id  = 0;

  function automatic vec_t mk(input logic r, input logic c, input logic q0, input logic q1,
                              input logic d0, input logic d1,
                              input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                              input logic [1:0] eg, input logic [1:0] ed,
                              input logic eb, input logic [WIDTH-1:0] ec);
    vec_t v;
    v.rst_n = r;  v.clr = c;  v.req0 = q0;  v.req1 = q1;
    v.dir0 = d0;  v.dir1 = d1; v.steps0 = s0; v.steps1 = s1;
    v.exp_gnt = eg; v.exp_done = ed; v.exp_busy = eb; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.id = row_id; e.gnt = v.exp_gnt; e.done = v.exp_done;
    e.busy = v.exp_busy; e.cnt = v.exp_cnt;
    sb.push_back(e);
    row_id++;
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    n_tests++;
    if (gnt !== e.gnt || done !== e.done || busy !== e.busy || cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL row%0d: got gnt=%b done=%b busy=%b cnt=%h, required gnt=%b done=%b busy=%b cnt=%h",
               e.id, gnt, done, busy, cnt, e.gnt, e.done, e.busy, e.cnt);
    end else begin
      $display("[TB] row%0d ok: gnt=%b done=%b busy=%b cnt=%h", e.id, gnt, done, busy, cnt);
    end
  endtask

  // Drive one cycle of inputs, then compare outputs 1 time unit after the next rising edge.
  task automatic apply(input vec_t v);
    rst_n = v.rst_n; clr = v.clr; req0 = v.req0; req1 = v.req1;
    dir0 = v.dir0; dir1 = v.dir1; steps0 = v.steps0; steps1 = v.steps1;
    push_exp(v);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
    dir0 = 1'b0; dir1 = 1'b0; steps0 = '0; steps1 = '0;

    // rst clr q0 q1 d0 d1 s0 s1 | gnt done busy cnt
    tbl.push_back(mk(0,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h0));
    // Up 3 from zero
    tbl.push_back(mk(1,0,1,0,1,0,4'd3,4'd0, 2'b01,2'b00,1,4'h0));
    tbl.push_back(mk(1,0,1,0,1,0,4'd3,4'd0, 2'b01,2'b00,1,4'h1));
    tbl.push_back(mk(1,0,1,0,1,0,4'd3,4'd0, 2'b01,2'b00,1,4'h2));
    tbl.push_back(mk(1,0,1,0,1,0,4'd3,4'd0, 2'b01,2'b01,1,4'h3));
    tbl.push_back(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h3));
    // clr together with a request: clear and grant on the same edge, then up 1
    tbl.push_back(mk(1,1,1,0,1,0,4'd1,4'd0, 2'b01,2'b00,1,4'h0));
    tbl.push_back(mk(1,0,1,0,1,0,4'd1,4'd0, 2'b01,2'b01,1,4'h1));
    tbl.push_back(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h1));
    // Down 3 from 1 wraps through zero
    tbl.push_back(mk(1,0,0,1,0,0,4'd0,4'd3, 2'b10,2'b00,1,4'h1));
    tbl.push_back(mk(1,0,0,1,0,0,4'd0,4'd3, 2'b10,2'b00,1,4'h0));
    tbl.push_back(mk(1,0,0,1,0,0,4'd0,4'd3, 2'b10,2'b00,1,4'hF));
    tbl.push_back(mk(1,0,0,1,0,0,4'd0,4'd3, 2'b10,2'b10,1,4'hE));
    tbl.push_back(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'hE));
    // Zero-step session
    tbl.push_back(mk(1,0,1,0,1,0,4'd0,4'd0, 2'b01,2'b01,1,4'hE));
    tbl.push_back(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'hE));
    // clr in RUN ignored; dir/steps changes after grant ignored; F+1 wraps to 0
    tbl.push_back(mk(1,0,0,1,0,1,4'd0,4'd2, 2'b10,2'b00,1,4'hE));
    tbl.push_back(mk(1,1,0,1,0,0,4'd0,4'd7, 2'b10,2'b00,1,4'hF));
    tbl.push_back(mk(1,0,0,1,0,0,4'd0,4'd7, 2'b10,2'b10,1,4'h0));
    tbl.push_back(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h0));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Count up to 9, then clr in IDLE
    apply(mk(1,0,1,0,1,0,4'd9,4'd0, 2'b01,2'b00,1,4'h0));
    for (int k = 1; k <= 9; k++) begin
      apply(mk(1,0,1,0,1,0,4'd9,4'd0, 2'b01,(k == 9) ? 2'b01 : 2'b00,1,4'(k)));
    end
    apply(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h9));
    apply(mk(1,1,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h0));

    // Abort after 2 of 5 up-steps; next grant goes to requester 1
    apply(mk(1,0,1,0,1,0,4'd5,4'd0, 2'b01,2'b00,1,4'h0));
    apply(mk(1,0,1,0,1,0,4'd5,4'd0, 2'b01,2'b00,1,4'h1));
    apply(mk(1,0,1,0,1,0,4'd5,4'd0, 2'b01,2'b00,1,4'h2));
    apply(mk(1,0,0,0,1,0,4'd5,4'd0, 2'b00,2'b00,0,4'h2));
    apply(mk(1,0,1,1,1,1,4'd5,4'd1, 2'b10,2'b00,1,4'h2));
    apply(mk(1,0,1,1,1,1,4'd5,4'd1, 2'b10,2'b10,1,4'h3));
    apply(mk(1,0,0,0,0,0,4'd0,4'd0, 2'b00,2'b00,0,4'h3));

    // Asynchronous reset in mid-RUN, checked before any further clock edge
    apply(mk(1,0,1,0,1,0,4'd5,4'd0, 2'b01,2'b00,1,4'h3));
    apply(mk(1,0,1,0,1,0,4'd5,4'd0, 2'b01,2'b00,1,4'h4));
    #2;
    rst_n = 1'b0;
    push_exp(mk(0,0,1,0,1,0,4'd5,4'd0, 2'b00,2'b00,0,4'h0));
    #1;
    check_front();
    apply(mk(0,0,1,1,1,0,4'd2,4'd2, 2'b00,2'b00,0,4'h0));

    // Both requesting from reset: alternate grants starting with requester 0
    for (int r = 0; r < 2; r++) begin
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b01,2'b00,1,4'h0));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b01,2'b00,1,4'h1));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b01,2'b01,1,4'h2));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b00,2'b00,0,4'h2));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b10,2'b00,1,4'h2));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b10,2'b00,1,4'h1));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b10,2'b10,1,4'h0));
      apply(mk(1,0,1,1,1,0,4'd2,4'd2, 2'b00,2'b00,0,4'h0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
